// File: rtl/run_checker_module.sv
// rtl/run_checker_module.sv - receive-side checker for the 3-bit running-light bus
//
// Purpose:
//   Watches LED_In for the ring 001 -> 010 -> 100 -> 000 -> 001.
//   It checks the step order and the dwell time between steps.
//   It reports lock, one-cycle sequence and timing error pulses, and a count
//   of completed rotations seen while locked.
//
// Ports:
//   CLK       in   1  system clock, rising edge
//   RST       in   1  synchronous reset, active-high
//   LED_In    in   3  observed running-light bus, synchronous to CLK
//   Locked    out  1  high while order and timing are verified
//   Err_Seq   out  1  one-cycle pulse on an illegal transition while locked
//   Err_Time  out  1  one-cycle pulse on a dwell-window miss or timeout while locked
//   Rot_Cnt   out  8  000->001 transitions accepted while locked (wraps)

`timescale 1ns/1ps

module run_checker_module #(
  parameter int unsigned     W       = 26,
  parameter logic [W-1:0]    T_DWELL = 26'd24_999_999,
  parameter logic [W-1:0]    TOL     = 26'd16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] LED_In,
  output logic       Locked,
  output logic       Err_Seq,
  output logic       Err_Time,
  output logic [7:0] Rot_Cnt
);

  localparam logic [W-1:0] DW_MAX = T_DWELL + TOL;
  localparam logic [W-1:0] DW_MIN = T_DWELL - TOL;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [2:0]   r_prev_q, r_prev_d;
  logic [W-1:0] dwell_q, dwell_d;
  logic [2:0]   acq_cnt_q, acq_cnt_d;
  logic         locked_q, locked_d;
  logic         err_seq_q, err_seq_d;
  logic         err_time_q, err_time_d;
  logic [7:0]   rot_cnt_q, rot_cnt_d;

  logic       chg;
  logic       succ_valid;
  logic [2:0] succ;
  logic       legal;
  logic       in_win;
  logic       timeout;

  // Only the four ring values have a legal successor; a change out of any
  // other value is illegal by construction.
  always_comb begin
    succ_valid = 1'b1;
    succ       = 3'b000;
    unique case (r_prev_q)
      3'b001:  succ = 3'b010;
      3'b010:  succ = 3'b100;
      3'b100:  succ = 3'b000;
      3'b000:  succ = 3'b001;
      default: succ_valid = 1'b0;
    endcase
  end

  assign chg     = (LED_In != r_prev_q);
  assign legal   = chg && succ_valid && (LED_In == succ);
  // Window and timeout use the dwell value before this edge's update.
  assign in_win  = (dwell_q >= DW_MIN) && (dwell_q <= DW_MAX);
  assign timeout = !chg && (dwell_q == DW_MAX);

  always_comb begin
    state_d    = state_q;
    r_prev_d   = LED_In;
    acq_cnt_d  = acq_cnt_q;
    locked_d   = locked_q;
    err_seq_d  = 1'b0;
    err_time_d = 1'b0;
    rot_cnt_d  = rot_cnt_q;

    // Saturating dwell keeps a stalled bus pinned at the timeout value, so a
    // held value triggers timeout once and is then ignored outside LOCKED.
    if (chg) begin
      dwell_d = '0;
    end else if (dwell_q == DW_MAX) begin
      dwell_d = dwell_q;
    end else begin
      dwell_d = dwell_q + 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (legal) begin
          state_d   = ST_ACQ;
          acq_cnt_d = 3'd1;
        end
      end
      ST_ACQ: begin
        if (chg) begin
          if (!legal) begin
            state_d = ST_IDLE;
          end else if (in_win) begin
            if (acq_cnt_q == 3'd3) begin
              state_d  = ST_LOCKED;
              locked_d = 1'b1;
            end
            acq_cnt_d = acq_cnt_q + 3'd1;
          end else begin
            acq_cnt_d = 3'd1;
          end
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (chg) begin
          // Illegal wins over out-of-window so only one error pulse fires.
          if (!legal) begin
            state_d   = ST_IDLE;
            locked_d  = 1'b0;
            err_seq_d = 1'b1;
          end else if (!in_win) begin
            state_d    = ST_ACQ;
            acq_cnt_d  = 3'd1;
            locked_d   = 1'b0;
            err_time_d = 1'b1;
          end else if (r_prev_q == 3'b000) begin
            rot_cnt_d = rot_cnt_q + 8'd1;
          end
        end else if (timeout) begin
          state_d    = ST_IDLE;
          locked_d   = 1'b0;
          err_time_d = 1'b1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        locked_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      r_prev_q   <= 3'b001;
      dwell_q    <= '0;
      acq_cnt_q  <= 3'd0;
      locked_q   <= 1'b0;
      err_seq_q  <= 1'b0;
      err_time_q <= 1'b0;
      rot_cnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      r_prev_q   <= r_prev_d;
      dwell_q    <= dwell_d;
      acq_cnt_q  <= acq_cnt_d;
      locked_q   <= locked_d;
      err_seq_q  <= err_seq_d;
      err_time_q <= err_time_d;
      rot_cnt_q  <= rot_cnt_d;
    end
  end

  assign Locked   = locked_q;
  assign Err_Seq  = err_seq_q;
  assign Err_Time = err_time_q;
  assign Rot_Cnt  = rot_cnt_q;

endmodule

// File: tb/tb_run_checker_module.sv
// tb/tb_run_checker_module.sv - randomized self-checking bench for run_checker_module

`timescale 1ns/1ps

module tb_run_checker_module;

  localparam int unsigned  W       = 26;
  localparam logic [W-1:0] T_DWELL = 26'd9;
  localparam logic [W-1:0] TOL     = 26'd1;
  localparam longint       T_I     = 9;
  localparam longint       TOL_I   = 1;

  logic       CLK;
  logic       RST;
  logic [2:0] LED_In;
  logic       Locked;
  logic       Err_Seq;
  logic       Err_Time;
  logic [7:0] Rot_Cnt;

  run_checker_module #(.W(W), .T_DWELL(T_DWELL), .TOL(TOL)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .LED_In   (LED_In),
    .Locked   (Locked),
    .Err_Seq  (Err_Seq),
    .Err_Time (Err_Time),
    .Rot_Cnt  (Rot_Cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: tracks time since the last change in absolute cycles,
  // and the mode as "hunting / collecting good steps / locked".
  logic [2:0] ring [4] = '{3'b001, 3'b010, 3'b100, 3'b000};
  longint     cyc = 0;
  longint     m_last = 0;
  logic [2:0] m_prev = 3'b001;
  int         m_mode = 0;    // 0 hunting, 1 collecting, 2 locked
  int         m_good = 0;
  int         m_rot  = 0;
  bit         m_es   = 0;
  bit         m_et   = 0;
  int         idx    = 0;

  function automatic bit is_next(input logic [2:0] from, input logic [2:0] to);
    for (int i = 0; i < 4; i++)
      if (ring[i] == from) return ring[(i + 1) % 4] == to;
    return 1'b0;
  endfunction

  task automatic model(input bit rst, input logic [2:0] led);
    longint dw;
    bit chg, legal, inwin, tout;
    cyc++;
    m_es = 0;
    m_et = 0;
    if (rst) begin
      m_prev = 3'b001; m_last = cyc; m_mode = 0; m_good = 0; m_rot = 0;
      return;
    end
    chg   = (led != m_prev);
    dw    = cyc - 1 - m_last;
    if (dw > T_I + TOL_I) dw = T_I + TOL_I;
    legal = chg && is_next(m_prev, led);
    inwin = (dw >= T_I - TOL_I) && (dw <= T_I + TOL_I);
    tout  = !chg && (dw == T_I + TOL_I);
    case (m_mode)
      0: if (legal) begin m_mode = 1; m_good = 1; end
      1: begin
        if (chg) begin
          if (!legal) m_mode = 0;
          else if (inwin) begin m_good++; if (m_good == 4) m_mode = 2; end
          else m_good = 1;
        end else if (tout) m_mode = 0;
      end
      default: begin
        if (chg) begin
          if (!legal) begin m_es = 1; m_mode = 0; end
          else if (!inwin) begin m_et = 1; m_mode = 1; m_good = 1; end
          else if (m_prev == 3'b000) m_rot = (m_rot + 1) % 256;
        end else if (tout) begin m_et = 1; m_mode = 0; end
      end
    endcase
    if (chg) m_last = cyc;
    m_prev = led;
  endtask

  task automatic step(input bit rst, input logic [2:0] led);
    RST    = rst;
    LED_In = led;
    @(posedge CLK);
    model(rst, led);
    #1;
    check("locked",   {31'd0, Locked},   {31'd0, m_mode == 2});
    check("err_seq",  {31'd0, Err_Seq},  {31'd0, m_es});
    check("err_time", {31'd0, Err_Time}, {31'd0, m_et});
    check("rot_cnt",  {24'd0, Rot_Cnt},  m_rot);
    check("err_excl", {31'd0, Err_Seq & Err_Time}, 32'd0);
  endtask

  task automatic hold(input logic [2:0] led, input int n);
    for (int k = 0; k < n; k++) step(1'b0, led);
  endtask

  task automatic run_steps(input int count, input int dwell);
    for (int k = 0; k < count; k++) begin
      idx = (idx + 1) % 4;
      hold(ring[idx], dwell);
    end
  endtask

  initial begin
    RST    = 1'b1;
    LED_In = 3'b000;

    for (int k = 0; k < 3; k++) step(1'b1, 3'($urandom_range(0, 7)));

    idx = 0;
    hold(3'b001, 10);
    run_steps(12, 10);

    while (ring[idx] != 3'b001) run_steps(1, 10);
    run_steps(1, 10);
    hold(3'b110, 15);
    idx = 0;
    hold(3'b001, 10);
    run_steps(8, 10);

    run_steps(1, 7);
    run_steps(3, 10);
    run_steps(4, 10);

    while (ring[idx] != 3'b100) run_steps(1, 10);
    hold(3'b100, 15);

    run_steps(8, 10);
    run_steps(256 * 4, 10);
    hold(ring[idx], 4);
    step(1'b1, ring[idx]);
    idx = 0;
    hold(3'b001, 6);
    run_steps(8, 10);

    for (int k = 0; k < 400; k++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        step(1'b1, 3'($urandom_range(0, 7)));
        idx = 0;
        hold(3'b001, $urandom_range(1, 10));
      end else if (r < 10) begin
        hold(3'($urandom_range(0, 7)), $urandom_range(1, 12));
      end else begin
        run_steps(1, (r < 70) ? 10 : $urandom_range(6, 13));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
